// File: rtl/floo_reduction_alu.sv
// Reduction offload ALU: lane-wise add/min/max computed at the input, then a stallable in-order pipeline.
// Optional unsupported-op counter enabled by defining FLOO_RED_ALU_ERR_CNT_EN.
package floo_reduction_alu_pkg;
    typedef enum logic [2:0] {
        AddRed,
        MinRed,
        MaxRed,
        MinURed,
        MaxURed,
        SeqAW,
        SelectAW,
        CollectB
    } collect_op_e;
endpackage

module floo_reduction_alu
    import floo_reduction_alu_pkg::*;
#(
    parameter type         reduction_data_t = logic [63:0],
    parameter int unsigned LaneWidth        = 64,
    parameter int unsigned PipelineDepth    = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            operands_valid_i,
    output logic            operands_ready_o,
    input  reduction_data_t operand1_i,
    input  reduction_data_t operand2_i,
    input  collect_op_e     operation_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output reduction_data_t result_o,
    output logic            unsupported_o,
    output logic [15:0]     err_cnt_o
);
    localparam int unsigned W        = $bits(reduction_data_t);
    localparam int unsigned NumLanes = W / LaneWidth;

    logic [W-1:0] op1_w, op2_w, res_s0;
    logic         unsup_s0;

    assign op1_w = operand1_i;
    assign op2_w = operand2_i;

    always_comb begin
        logic [LaneWidth-1:0] lane_a, lane_b, lane_r;
        res_s0   = op1_w;
        unsup_s0 = 1'b0;
        lane_a   = '0;
        lane_b   = '0;
        lane_r   = '0;
        for (int unsigned l = 0; l < NumLanes; l++) begin
            lane_a = op1_w[l*LaneWidth +: LaneWidth];
            lane_b = op2_w[l*LaneWidth +: LaneWidth];
            // Ties pick operand a, so min/max are deterministic on equal inputs.
            case (operation_i)
                AddRed:  lane_r = lane_a + lane_b;
                MinRed:  lane_r = ($signed(lane_b) < $signed(lane_a)) ? lane_b : lane_a;
                MaxRed:  lane_r = ($signed(lane_b) > $signed(lane_a)) ? lane_b : lane_a;
                MinURed: lane_r = (lane_b < lane_a) ? lane_b : lane_a;
                MaxURed: lane_r = (lane_b > lane_a) ? lane_b : lane_a;
                default: begin
                    lane_r   = lane_a;
                    unsup_s0 = 1'b1;
                end
            endcase
            res_s0[l*LaneWidth +: LaneWidth] = lane_r;
        end
    end

    if (PipelineDepth == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst   = clk_i ^ rst_i;
        assign result_valid_o   = operands_valid_i;
        assign operands_ready_o = result_ready_i;
        assign result_o         = res_s0;
        assign unsupported_o    = operands_valid_i & unsup_s0;
    end else begin : g_pipe
        localparam int unsigned Last = PipelineDepth - 1;

        logic [PipelineDepth-1:0]        valid_q, valid_d, advance;
        logic [PipelineDepth-1:0]        unsup_q, unsup_d;
        logic [PipelineDepth-1:0][W-1:0] data_q, data_d;

        // Walk back from the output so a bubble anywhere lets upstream stages move.
        always_comb begin
            logic adv;
            advance = '0;
            adv     = result_ready_i | ~valid_q[Last];
            for (int k = int'(Last); k >= 0; k--) begin
                if (k != int'(Last)) begin
                    adv = ~valid_q[k] | adv;
                end
                advance[k] = adv;
            end
        end

        always_comb begin
            valid_d = valid_q;
            unsup_d = unsup_q;
            data_d  = data_q;
            if (advance[0]) begin
                valid_d[0] = operands_valid_i;
                unsup_d[0] = unsup_s0;
                data_d[0]  = res_s0;
            end
            for (int k = 1; k < int'(PipelineDepth); k++) begin
                if (advance[k]) begin
                    valid_d[k] = valid_q[k-1];
                    unsup_d[k] = unsup_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= '0;
                unsup_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                unsup_q <= unsup_d;
                data_q  <= data_d;
            end
        end

        assign operands_ready_o = advance[0];
        assign result_valid_o   = valid_q[Last];
        assign result_o         = data_q[Last];
        assign unsupported_o    = unsup_q[Last];
    end

`ifdef FLOO_RED_ALU_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (result_valid_o && result_ready_i && unsupported_o && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_reduction_alu.sv
// Scoreboard bench: four DUT instances (depth 0/1/3 and a depth-2 reset target) with directed vectors.
module tb_floo_reduction_alu;
    import floo_reduction_alu_pkg::*;

    typedef logic [63:0] data_t;
    typedef struct packed {
        logic [63:0] data;
        logic        unsup;
    } exp_t;

`ifdef FLOO_RED_ALU_ERR_CNT_EN
    localparam logic [15:0] ExpErrCnt = 16'd1;
`else
    localparam logic [15:0] ExpErrCnt = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index = instance: 0 -> depth 0, 1 -> depth 1 (32-bit lanes), 2 -> depth 2, 3 -> depth 3.
    logic        v    [4];
    logic        ordy [4];
    data_t       a    [4];
    data_t       b    [4];
    collect_op_e op   [4];
    logic        rv   [4];
    logic        rr   [4];
    data_t       res  [4];
    logic        un   [4];
    logic [15:0] ec   [4];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int n_cmp = 0;
    int n_err = 0;

    floo_reduction_alu #(.reduction_data_t(data_t), .LaneWidth(64), .PipelineDepth(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .operands_valid_i(v[0]), .operands_ready_o(ordy[0]),
        .operand1_i(a[0]), .operand2_i(b[0]), .operation_i(op[0]), .result_valid_o(rv[0]),
        .result_ready_i(rr[0]), .result_o(res[0]), .unsupported_o(un[0]), .err_cnt_o(ec[0])
    );
    floo_reduction_alu #(.reduction_data_t(data_t), .LaneWidth(32), .PipelineDepth(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .operands_valid_i(v[1]), .operands_ready_o(ordy[1]),
        .operand1_i(a[1]), .operand2_i(b[1]), .operation_i(op[1]), .result_valid_o(rv[1]),
        .result_ready_i(rr[1]), .result_o(res[1]), .unsupported_o(un[1]), .err_cnt_o(ec[1])
    );
    floo_reduction_alu #(.reduction_data_t(data_t), .LaneWidth(64), .PipelineDepth(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .operands_valid_i(v[2]), .operands_ready_o(ordy[2]),
        .operand1_i(a[2]), .operand2_i(b[2]), .operation_i(op[2]), .result_valid_o(rv[2]),
        .result_ready_i(rr[2]), .result_o(res[2]), .unsupported_o(un[2]), .err_cnt_o(ec[2])
    );
    floo_reduction_alu #(.reduction_data_t(data_t), .LaneWidth(64), .PipelineDepth(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .operands_valid_i(v[3]), .operands_ready_o(ordy[3]),
        .operand1_i(a[3]), .operand2_i(b[3]), .operation_i(op[3]), .result_valid_o(rv[3]),
        .result_ready_i(rr[3]), .result_o(res[3]), .unsupported_o(un[3]), .err_cnt_o(ec[3])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input int d, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, " unexpected result"}, 64'(rv[d]), 64'd0);
        end else begin
            e = q.pop_front();
            check({tag, " data"}, res[d], e.data);
            check({tag, " unsup"}, 64'(un[d]), 64'(e.unsup));
        end
    endtask

    // Monitors: a result is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) if (!rst && rv[0] && rr[0]) pop_cmp("d0", 0, q0);
    always @(negedge clk) if (!rst && rv[1] && rr[1]) pop_cmp("d1", 1, q1);
    always @(negedge clk) if (!rst && rv[2] && rr[2]) pop_cmp("d2", 2, q2);
    always @(negedge clk) if (!rst && rv[3] && rr[3]) pop_cmp("d3", 3, q3);

    // Called at posedge+1; returns at posedge+1 right after the operand handshake.
    task automatic send(input int d, input collect_op_e o, input data_t x, input data_t y,
                        input data_t er, input logic eu);
        exp_t e;
        int   c;
        e.data  = er;
        e.unsup = eu;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
        v[d]  = 1'b1;
        op[d] = o;
        a[d]  = x;
        b[d]  = y;
        c     = 0;
        @(negedge clk);
        while (!ordy[d] && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("send handshake", 64'(ordy[d]), 64'd1);
        @(posedge clk);
        #1;
        v[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            v[i]  = 1'b0;
            rr[i] = 1'b1;
            a[i]  = '0;
            b[i]  = '0;
            op[i] = AddRed;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready d1", 64'(ordy[1]), 64'd1);
        check("reset ready d3", 64'(ordy[3]), 64'd1);
        check("reset valid d1", 64'(rv[1]), 64'd0);
        check("reset valid d3", 64'(rv[3]), 64'd0);
        check("reset result d1", res[1], 64'd0);
        check("reset unsup d1", 64'(un[1]), 64'd0);
        check("reset err_cnt d1", 64'(ec[1]), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 32-bit lanes, depth 1
        send(1, AddRed, 64'hFFFFFFFF_00000001, 64'h00000001_00000002, 64'h00000000_00000003, 1'b0);
        @(negedge clk);
        check("d1 latency", 64'(rv[1]), 64'd1);
        @(posedge clk);
        #1;
        send(1, MinRed, 64'h80000000_00000005, 64'h00000001_FFFFFFFF, 64'h80000000_FFFFFFFF, 1'b0);
        send(1, MinURed, 64'h80000000_00000005, 64'h00000001_FFFFFFFF, 64'h00000001_00000005,
             1'b0);
        send(1, MaxRed, 64'h80000000_00000005, 64'h00000001_FFFFFFFF, 64'h00000001_00000005,
             1'b0);
        send(1, SeqAW, 64'h0000000000001234, 64'h0000000000009999, 64'h0000000000001234, 1'b1);
        @(posedge clk);
        #1;
        check("d1 err_cnt", 64'(ec[1]), 64'(ExpErrCnt));

        // 64-bit lanes, depth 3, no backpressure
        send(3, MinRed, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        send(3, MinURed, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd1, 1'b0);
        send(3, MaxURed, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        send(3, MaxRed, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd1, 1'b0);
        send(3, AddRed, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0, 1'b0);
        send(3, MinRed, 64'd7, 64'd7, 64'd7, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: three fill the pipe, the fourth must stall
        rr[3] = 1'b0;
        for (int i = 0; i < 3; i++) send(3, AddRed, 64'(i), 64'd100, 64'(i + 100), 1'b0);
        v[3]  = 1'b1;
        op[3] = AddRed;
        a[3]  = 64'd3;
        b[3]  = 64'd100;
        @(negedge clk);
        check("d3 full ready", 64'(ordy[3]), 64'd0);
        check("d3 full valid", 64'(rv[3]), 64'd1);
        check("d3 hold 0", res[3], 64'd100);
        @(negedge clk);
        check("d3 hold 1", res[3], 64'd100);
        @(posedge clk);
        #1;
        rr[3] = 1'b1;
        send(3, AddRed, 64'd3, 64'd100, 64'd103, 1'b0);
        send(3, AddRed, 64'd4, 64'd100, 64'd104, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Combinational depth 0
        send(0, MaxRed, 64'hFFFFFFFF_FFFFFFFD, 64'd5, 64'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rr[0] = i[0];
            #1;
            check("d0 ready follows", 64'(ordy[0]), 64'(i[0]));
            check("d0 valid idle", 64'(rv[0]), 64'd0);
            @(posedge clk);
            #1;
        end
        rr[0] = 1'b0;
        v[0]  = 1'b1;
        op[0] = AddRed;
        a[0]  = 64'd1;
        b[0]  = 64'd2;
        #1;
        check("d0 comb valid", 64'(rv[0]), 64'd1);
        check("d0 comb result", res[0], 64'd3);
        v[0]  = 1'b0;
        rr[0] = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-flight on depth 2
        rr[2] = 1'b0;
        send(2, AddRed, 64'd10, 64'd1, 64'd11, 1'b0);
        send(2, AddRed, 64'd20, 64'd1, 64'd21, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("d2 rst valid", 64'(rv[2]), 64'd0);
        check("d2 rst result", res[2], 64'd0);
        check("d1 rst err_cnt", 64'(ec[1]), 64'd0);
        q2.delete();
        #1;
        rst   = 1'b0;
        rr[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d2 no stale", 64'(rv[2]), 64'd0);
        end
        @(posedge clk);
        #1;

        check("q0 drained", 64'(q0.size()), 64'd0);
        check("q1 drained", 64'(q1.size()), 64'd0);
        check("q3 drained", 64'(q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
